// File: rtl/gate_scheduler_pkg.sv
// Shared definitions for the gate scheduler, gate evaluator and LSTM top level.
// Latency: none (types, constants and a width helper only).
// Backpressure: not applicable.
package gate_scheduler_pkg;

  // Default Q-format of the signed fixed-point datapath word.
  localparam int QN_DEF = 6;
  localparam int QM_DEF = 11;

  // Word width: sign bit plus integer and fractional bits.
  function automatic int gate_bw(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  localparam int BW_DEF = QN_DEF + QM_DEF + 1;

  // Scheduler phases; PH0/PH1 line up with the evaluator's two internal phases.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH0  = 2'd1,
    ST_PH1  = 2'd2
  } gate_state_e;

endpackage

// File: rtl/gate_scheduler_rr_arbiter.sv
// Round-robin pick: first valid requester after last_grant, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);

  // Walk the requesters starting one past the last winner; take the first valid.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(last_grant) + k) % N);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/gate_scheduler.sv
// Time-shares one two-phase gate evaluator among N_REQ requesters, round-robin.
// Latency: 3 cycles from the accepting edge to resp_valid; one evaluation per 2 cycles.
// Backpressure: req_ready only in IDLE/PH1 and only to a valid requester; responses cannot stall.
module gate_scheduler
  import gate_scheduler_pkg::*;
#(
  parameter int QN    = QN_DEF,
  parameter int QM    = QM_DEF,
  parameter int N_REQ = 4,
  localparam int BW   = QN + QM + 1,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [N_REQ*BW-1:0] req_operand,
  output logic [N_REQ-1:0]  req_ready,
  output logic [BW-1:0]     gate_operand,
  output logic              gate_reset,
  input  logic [BW-1:0]     gate_result,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [BW-1:0]     resp_result,
  output logic              busy
);

  gate_state_e    state_q, state_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;
  logic [BW-1:0]  op_q, op_d;
  logic [IDW-1:0] id_q, id_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             can_accept;
  logic             accept;

  rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Grants are offered only between evaluations, and never while reset is held.
  assign can_accept = reset && ((state_q == ST_IDLE) || (state_q == ST_PH1));
  assign req_ready  = can_accept ? grant : '0;
  assign accept     = |req_ready;

  // Next state, operand/index capture and response strobe.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    id_d         = id_q;
    resp_valid_d = (state_q == ST_PH1);
    resp_id_d    = id_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PH0;
      ST_PH0:  state_d = ST_PH1;
      ST_PH1:  state_d = accept ? ST_PH0 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      last_grant_d = grant_idx;
      id_d         = grant_idx;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i]) op_d = req_operand[i*BW +: BW];
      end
    end
  end

  // State and capture registers; reset discards any in-flight evaluation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      op_q         <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // Evaluator is held in phase 0 whenever no evaluation is running.
  assign gate_operand = op_q;
  assign gate_reset   = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_result  = gate_result;

endmodule
